// File: rtl/cg_nz_scan_pp_if.sv
// rtl/cg_nz_scan_pp_if.sv - load and result handshakes of the coefficient-group scanner
interface cg_nz_scan_pp_if #(
    parameter int COEFF_W = 16,
    parameter int CG_SIZE = 16
);
    localparam int POS_W = $clog2(CG_SIZE);

    logic                       valid_in;
    logic                       ready_in;
    logic signed [COEFF_W-1:0]  coef_in;
    logic [POS_W-1:0]           position_in;
    logic                       load_done;
    logic [CG_SIZE*POS_W-1:0]   scan_order;
    logic                       valid_out;
    logic                       ready_out;
    logic [POS_W-1:0]           firstNZ;
    logic [POS_W-1:0]           lastNZ;
    logic                       hasNZ;
    logic                       sum_parity;
    logic                       sbh_flag;

    modport master (
        output valid_in, coef_in, position_in, load_done, scan_order, ready_out,
        input  ready_in, valid_out, firstNZ, lastNZ, hasNZ, sum_parity, sbh_flag
    );

    modport slave (
        input  valid_in, coef_in, position_in, load_done, scan_order, ready_out,
        output ready_in, valid_out, firstNZ, lastNZ, hasNZ, sum_parity, sbh_flag
    );
endinterface

// File: rtl/cg_nz_scan_pp.sv
// rtl/cg_nz_scan_pp.sv - ping-pong CG scanner for sign bit hiding; SBH_PARITY_EN enables parity/sbh_flag
module cg_nz_scan_pp #(
    parameter int COEFF_W    = 16,
    parameter int CG_SIZE    = 16,
    parameter int LANES      = 4,
    parameter int SBH_THRESH = 4
) (
    input logic             clk,
    input logic             rst_n,
    cg_nz_scan_pp_if.slave  bus
);
    localparam int POS_W = $clog2(CG_SIZE);
    localparam int G     = CG_SIZE / LANES;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;

    if ((CG_SIZE < 4) || ((CG_SIZE & (CG_SIZE - 1)) != 0) || ((LANES & (LANES - 1)) != 0) ||
        (LANES > CG_SIZE) || (SBH_THRESH < 0) || (SBH_THRESH > CG_SIZE)) begin : g_bad_params
        $error("cg_nz_scan_pp: illegal parameter combination");
    end

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_t;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} scan_st_t;

    logic signed [COEFF_W-1:0]  mem [2][CG_SIZE];
    logic [CG_SIZE*POS_W-1:0]   order [2];
    bank_st_t                   bst [2];
    logic                       wr_bank, rd_bank;
    scan_st_t                   state;
    logic [GW-1:0]              g;
    logic [POS_W-1:0]           acc_first, acc_last, nxt_first, nxt_last;
    logic                       acc_has, nxt_has;
    logic [POS_W-1:0]           first_q, last_q;
    logic                       has_q, valid_q;
    logic [POS_W-1:0]           idx, pos;
    logic signed [COEFF_W-1:0]  coef;
    logic                       wr_en, done_en, last_grp;

    assign bus.ready_in  = (bst[wr_bank] != B_FULL);
    assign wr_en         = bus.valid_in && bus.ready_in;
    assign done_en       = bus.load_done && bus.ready_in;
    assign last_grp      = (g == GW'(G - 1));
    assign bus.valid_out = valid_q;
    assign bus.firstNZ   = first_q;
    assign bus.lastNZ    = last_q;
    assign bus.hasNZ     = has_q;

`ifdef SBH_PARITY_EN
    logic             acc_par, nxt_par, par_q, sbh_q;
    logic [POS_W:0]   dist;
    assign dist           = {1'b0, nxt_last} - {1'b0, nxt_first};
    assign bus.sum_parity = par_q;
    assign bus.sbh_flag   = sbh_q;
`else
    assign bus.sum_parity = 1'b0;
    assign bus.sbh_flag   = 1'b0;
`endif

    // Lanes are visited in ascending scan index so the first hit in a group wins firstNZ.
    always_comb begin
        nxt_first = acc_first;
        nxt_last  = acc_last;
        nxt_has   = acc_has;
        idx       = '0;
        pos       = '0;
        coef      = '0;
`ifdef SBH_PARITY_EN
        nxt_par   = acc_par;
`endif
        for (int l = 0; l < LANES; l++) begin
            idx  = POS_W'(int'(g) * LANES + l);
            pos  = order[rd_bank][int'(idx)*POS_W +: POS_W];
            coef = mem[rd_bank][pos];
            if (coef != '0) begin
                if (!nxt_has)
                    nxt_first = idx;
                nxt_last = idx;
                nxt_has  = 1'b1;
            end
`ifdef SBH_PARITY_EN
            nxt_par = nxt_par ^ coef[0];
`endif
        end
    end

    // Loader and scanner never touch the same bank in one cycle: the scanned bank is FULL,
    // so the loader is stalled whenever both pointers coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < CG_SIZE; p++)
                    mem[b][p] <= '0;
                order[b] <= '0;
                bst[b]   <= B_EMPTY;
            end
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            state     <= S_IDLE;
            g         <= '0;
            acc_first <= '1;
            acc_last  <= '1;
            acc_has   <= 1'b0;
            first_q   <= '1;
            last_q    <= '1;
            has_q     <= 1'b0;
            valid_q   <= 1'b0;
`ifdef SBH_PARITY_EN
            acc_par   <= 1'b0;
            par_q     <= 1'b0;
            sbh_q     <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                mem[wr_bank][bus.position_in] <= bus.coef_in;
                if (bst[wr_bank] == B_EMPTY)
                    bst[wr_bank] <= B_FILLING;
            end
            if (done_en) begin
                bst[wr_bank]   <= B_FULL;
                order[wr_bank] <= bus.scan_order;
                wr_bank        <= ~wr_bank;
            end
            case (state)
                S_IDLE: begin
                    if (bst[rd_bank] == B_FULL) begin
                        state     <= S_SCAN;
                        g         <= '0;
                        acc_first <= '1;
                        acc_last  <= '1;
                        acc_has   <= 1'b0;
`ifdef SBH_PARITY_EN
                        acc_par   <= 1'b0;
`endif
                    end
                end
                S_SCAN: begin
                    acc_first <= nxt_first;
                    acc_last  <= nxt_last;
                    acc_has   <= nxt_has;
                    g         <= g + 1'b1;
`ifdef SBH_PARITY_EN
                    acc_par   <= nxt_par;
`endif
                    if (last_grp) begin
                        first_q <= nxt_first;
                        last_q  <= nxt_last;
                        has_q   <= nxt_has;
                        valid_q <= 1'b1;
`ifdef SBH_PARITY_EN
                        par_q   <= nxt_par;
                        sbh_q   <= nxt_has && (dist >= (POS_W+1)'(SBH_THRESH));
`endif
                        for (int p = 0; p < CG_SIZE; p++)
                            mem[rd_bank][p] <= '0;
                        bst[rd_bank] <= B_EMPTY;
                        rd_bank      <= ~rd_bank;
                        state        <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (valid_q && bus.ready_out) begin
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cg_nz_scan_pp.sv
// tb/tb_cg_nz_scan_pp.sv - directed self-checking bench for cg_nz_scan_pp
module tb_cg_nz_scan_pp;
`ifdef SBH_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [63:0] ident_ord, rev_ord;

    cg_nz_scan_pp_if bus ();

    cg_nz_scan_pp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int p, input int v);
        bus.valid_in    = 1'b1;
        bus.position_in = 4'(p);
        bus.coef_in     = 16'(v);
        @(negedge clk);
        bus.valid_in    = 1'b0;
    endtask

    task automatic done(input logic [63:0] ord);
        bus.scan_order = ord;
        bus.load_done  = 1'b1;
        @(negedge clk);
        bus.load_done  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.valid_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    endtask

    task automatic check_res(input string tag, input int f, input int l, input bit h,
                             input bit p, input bit s);
        check({tag, "_first"},  32'(bus.firstNZ),    32'(f));
        check({tag, "_last"},   32'(bus.lastNZ),     32'(l));
        check({tag, "_has"},    32'(bus.hasNZ),      32'(h));
        check({tag, "_parity"}, 32'(bus.sum_parity), 32'(p & PEN));
        check({tag, "_sbh"},    32'(bus.sbh_flag),   32'(s & PEN));
    endtask

    task automatic accept();
        bus.ready_out = 1'b1;
        @(negedge clk);
        bus.ready_out = 1'b0;
        check("accept_drop", 32'(bus.valid_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        for (int i = 0; i < 16; i++) begin
            ident_ord[i*4 +: 4] = 4'(i);
            rev_ord[i*4 +: 4]   = 4'(15 - i);
        end
        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.coef_in = '0; bus.position_in = '0;
        bus.load_done = 1'b0; bus.scan_order = '0; bus.ready_out = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_ready_in", 32'(bus.ready_in), 32'd1);
        check_res("rst", 15, 15, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // CG 1: latency and basic result
        wr(3, 5); wr(12, -2); done(ident_ord);
        repeat (4) @(negedge clk);
        check("t1_lat_early", 32'(bus.valid_out), 32'd0);
        @(negedge clk);
        check("t1_lat_exact", 32'(bus.valid_out), 32'd1);
        check_res("t1", 3, 12, 1, 1, 1);
        repeat (2) @(negedge clk);
        check("t1_hold", 32'(bus.firstNZ), 32'd3);
        accept();

        wr(7, 4); done(ident_ord);
        wait_valid("t2");
        check_res("t2", 7, 7, 1, 0, 0);
        accept();

        // empty CG into a bank that previously held CG 1
        done(ident_ord);
        wait_valid("t3");
        check_res("t3", 15, 15, 0, 0, 0);
        accept();

        wr(0, 1); done(rev_ord);
        wait_valid("t4");
        check_res("t4", 15, 15, 1, 1, 0);
        accept();

        // three CGs back-to-back with downstream stalled
        wr(1, 3); done(ident_ord);
        wr(2, 6); wr(9, 1); done(ident_ord);
        check("t5_ready_low", 32'(bus.ready_in), 32'd0);
        wr(0, 8);
        check("t5_ready_low2", 32'(bus.ready_in), 32'd0);
        check("t5_valid_low", 32'(bus.valid_out), 32'd0);
        @(negedge clk);
        check("t5_ready_rise", 32'(bus.ready_in), 32'd1);
        check("t5_a_valid", 32'(bus.valid_out), 32'd1);
        wr(4, -3); wr(11, 2); done(ident_ord);
        check("t5_ready_full", 32'(bus.ready_in), 32'd0);
        bus.ready_out = 1'b1;
        wait_valid("t5a");
        check_res("t5a", 1, 1, 1, 1, 0);
        @(negedge clk);
        wait_valid("t5b");
        check_res("t5b", 2, 9, 1, 1, 1);
        @(negedge clk);
        wait_valid("t5c");
        check_res("t5c", 4, 11, 1, 1, 1);
        @(negedge clk);
        bus.ready_out = 1'b0;

        // reset during scan
        wr(5, 1); done(ident_ord);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_res("t6_rst", 15, 15, 0, 0, 0);
        check("t6_rst_valid", 32'(bus.valid_out), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.valid_out) seen++;
        end
        check("t6_no_valid", 32'(seen), 32'd0);
        check("t6_ready_in", 32'(bus.ready_in), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cg_nz_scan_pp.md
# cg_nz_scan_pp

Parametrised, double-buffered coefficient-group scanner for the Sign Bit Hiding unit. It loads the coefficients of one coefficient group (CG) into a ping-pong bank. It then scans that bank in a caller-supplied scan order, LANES positions per cycle, and reports first/last non-zero scan index, non-zero presence, sum-of-magnitude parity and the SBH eligibility flag. Results leave over a valid/ready handshake, so the next CG can be loaded while the current one is scanned.

## Interface
Parameters:
- COEFF_W, 16, signed coefficient width
- CG_SIZE, 16, coefficients per CG; power of two, ≥ 4
- POS_W, $clog2(CG_SIZE), position/index width (derived, not overridden)
- LANES, 4, scan positions examined per cycle; power of two, divides CG_SIZE
- SBH_THRESH, 4, minimum lastNZ − firstNZ distance for sign hiding

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  coefficient write strobe
- ready_in  out  1  a load bank is available
- coef_in  in  COEFF_W  signed coefficient
- position_in  in  POS_W  raster position in CG
- load_done  in  1  closes the current load bank
- scan_order  in  CG_SIZE*POS_W  slice i = raster position of scan index i; sampled with load_done
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts result
- firstNZ  out  POS_W  lowest scan index with non-zero coefficient
- lastNZ  out  POS_W  highest scan index with non-zero coefficient
- hasNZ  out  1  any non-zero coefficient in CG
- sum_parity  out  1  parity of Σ|coef|
- sbh_flag  out  1  hasNZ && (lastNZ − firstNZ ≥ SBH_THRESH)

## Operation
- Two banks. Each bank holds CG_SIZE coefficients and a scan-order copy. Each bank state is EMPTY, FILLING or FULL. wr_bank and rd_bank pointers toggle independently.
- Load: when valid_in && ready_in, coef_in is written to bank[wr_bank][position_in] and an EMPTY bank becomes FILLING. Rewriting a position overwrites it.
- When load_done && ready_in: the bank becomes FULL, scan_order is captured and wr_bank toggles. A write in the same cycle is included. load_done on an EMPTY bank yields an all-zero CG.
- ready_in = wr_bank bank not FULL. valid_in/load_done while ready_in=0 are ignored.
- Scanner FSM IDLE → SCAN → HOLD:
  - IDLE: if bank[rd_bank] FULL → SCAN, with group counter g=0, accumulators cleared.
  - SCAN: examine scan indices g*LANES … g*LANES+LANES−1 via the captured scan order. firstNZ takes the first hit only; lastNZ takes the latest hit. Parity XORs LSB of each coefficient (LSB of |x| = LSB of x). At g = CG_SIZE/LANES−1, register outputs, zero the bank, mark it EMPTY, toggle rd_bank → HOLD.
  - HOLD: valid_out=1. Outputs are stable until ready_out; on valid_out && ready_out → IDLE.
- No non-zero coefficient: firstNZ = lastNZ = all-ones, hasNZ=0, sbh_flag=0.
- Subtraction lastNZ − firstNZ is unsigned POS_W+1 bits; never negative when hasNZ.

## Timing
- Reset: valid_out=0, hasNZ=0, sum_parity=0, sbh_flag=0, firstNZ=lastNZ=all-ones, ready_in=1. Both banks are EMPTY and zeroed, both pointers 0, FSM IDLE.
- Let G = CG_SIZE/LANES. With load_done sampled at edge T, SCAN occupies cycles T+1…T+G and valid_out rises after edge T+G+1. Latency is G+1 cycles (5 at defaults) when the scanner is idle.
- A bank is freed at the end of SCAN, not at the handshake. The loader regains it during HOLD.
- Back-to-back CGs with ready_out held high give a throughput of one CG per G+2 cycles.
- Reset mid-load or mid-scan discards all banks and results; no valid_out follows.

## Configuration
- SBH_PARITY_EN defined: sum_parity and sbh_flag are computed as specified.
- Undefined: the parity accumulator and distance compare are not built, and sum_parity and sbh_flag are tied 0. firstNZ/lastNZ/hasNZ and timing are unchanged.

## Test plan
- Identity scan order, coef[3]=5, coef[12]=−2, rest 0 → firstNZ=3, lastNZ=12, hasNZ=1, sum_parity=1, sbh_flag=1, valid_out 5 cycles after load_done.
- Identity order, only coef[7]=4 → firstNZ=lastNZ=7, sum_parity=0, sbh_flag=0.
- load_done with no writes → hasNZ=0, firstNZ=lastNZ=15, sbh_flag=0; the bank's earlier contents are not visible.
- Reverse scan order (index i → position 15−i), coef[0]=1 → firstNZ=lastNZ=15, hasNZ=1.
- Three CGs loaded back-to-back with ready_out=0:
  - ready_in drops after the second load_done; a third-CG valid_in is ignored.
  - Raising ready_out delivers results in load order, and ready_in rises the cycle after the first bank is freed.
- Assert rst_n low during SCAN → all outputs at reset values, valid_out stays 0 afterwards, ready_in=1.
